// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port between the
// ALU writeback (port 0) and the load writeback (port 1). Each port owns a
// one-entry buffer. Arbitration is age-first for same-register writes and
// round-robin otherwise. Commit outputs are registered.
module regfile_write_arbiter #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Req0Valid,
   output logic              Req0Ready,
   input  logic [ADDR_W-1:0] Req0RW,
   input  logic [DATA_W-1:0] Req0Data,
   input  logic              Req1Valid,
   output logic              Req1Ready,
   input  logic [ADDR_W-1:0] Req1RW,
   input  logic [DATA_W-1:0] Req1Data,
   output logic              RegWr,
   output logic [ADDR_W-1:0] RW,
   output logic [DATA_W-1:0] BusW,
   output logic [31:0]       PendMask
);

   localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(ZERO_REG);
   localparam logic [31:0]       ZERO_MASK = 32'd1 << ZERO_REG;

   // Per-port write buffers
   logic              r_b0_v, r_b1_v;
   logic [ADDR_W-1:0] r_b0_rw, r_b1_rw;
   logic [DATA_W-1:0] r_b0_data, r_b1_data;

   // r_older: 1 when buffer 1 was loaded before buffer 0
   // r_rr:    1 when port 1 wins the next round-robin decision
   logic              r_older;
   logic              r_rr;

   // Registered commit outputs
   logic              r_regwr;
   logic [ADDR_W-1:0] r_rw;
   logic [DATA_W-1:0] r_busw;

   logic              w_both, w_same, w_g0, w_g1;
   logic              w_acc0, w_acc1, w_n0, w_n1;
   logic [ADDR_W-1:0] w_c_rw;
   logic [DATA_W-1:0] w_c_data;
   logic [31:0]       w_pend;

   // Grant selection from buffer state: single valid, else age, else round-robin
   always_comb begin
      w_both = r_b0_v & r_b1_v;
      w_same = (r_b0_rw == r_b1_rw) && (r_b0_rw != ZERO_IDX);
      w_g0   = 1'b0;
      w_g1   = 1'b0;
      if (w_both) begin
         if (w_same) begin
            w_g0 = ~r_older;
            w_g1 = r_older;
         end else begin
            w_g0 = ~r_rr;
            w_g1 = r_rr;
         end
      end else begin
         w_g0 = r_b0_v;
         w_g1 = r_b1_v;
      end
   end

   assign Req0Ready = ~Reset & (~r_b0_v | w_g0);
   assign Req1Ready = ~Reset & (~r_b1_v | w_g1);
   assign w_acc0    = Req0Valid & Req0Ready;
   assign w_acc1    = Req1Valid & Req1Ready;
   // Buffer occupancy after this edge, used to maintain the age flag
   assign w_n0      = w_acc0 | (r_b0_v & ~w_g0);
   assign w_n1      = w_acc1 | (r_b1_v & ~w_g1);
   assign w_c_rw    = w_g1 ? r_b1_rw   : r_b0_rw;
   assign w_c_data  = w_g1 ? r_b1_data : r_b0_data;

   // Buffer load/free, age and round-robin tracking, and commit registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_b0_v    <= 1'b0;
         r_b1_v    <= 1'b0;
         r_b0_rw   <= '0;
         r_b1_rw   <= '0;
         r_b0_data <= '0;
         r_b1_data <= '0;
         r_older   <= 1'b0;
         r_rr      <= 1'b0;
         r_regwr   <= 1'b0;
         r_rw      <= '0;
         r_busw    <= '0;
      end else begin
         if (w_acc0) begin
            r_b0_v    <= 1'b1;
            r_b0_rw   <= Req0RW;
            r_b0_data <= Req0Data;
         end else if (w_g0) begin
            r_b0_v    <= 1'b0;
         end

         if (w_acc1) begin
            r_b1_v    <= 1'b1;
            r_b1_rw   <= Req1RW;
            r_b1_data <= Req1Data;
         end else if (w_g1) begin
            r_b1_v    <= 1'b0;
         end

         // A simultaneous load makes port 0 the older entry
         if (w_n0 & w_n1) begin
            if (w_acc0 & ~w_acc1) begin
               r_older <= 1'b1;
            end else if (w_acc1) begin
               r_older <= 1'b0;
            end
         end

         // Pointer moves to the other port after a round-robin decision
         if (w_both & ~w_same) begin
            r_rr <= w_g0;
         end

         if (w_g0 | w_g1) begin
            r_rw    <= w_c_rw;
            r_busw  <= w_c_data;
            r_regwr <= (w_c_rw != ZERO_IDX);
         end else begin
            r_regwr <= 1'b0;
         end
      end
   end

   // Pending-write mask over buffered and in-flight writes
   always_comb begin
      w_pend = '0;
      if (r_b0_v) begin
         w_pend = w_pend | (32'd1 << r_b0_rw);
      end
      if (r_b1_v) begin
         w_pend = w_pend | (32'd1 << r_b1_rw);
      end
      if (r_regwr) begin
         w_pend = w_pend | (32'd1 << r_rw);
      end
      w_pend = w_pend & ~ZERO_MASK;
      if (Reset) begin
         w_pend = '0;
      end
   end

   assign RegWr    = r_regwr;
   assign RW       = r_rw;
   assign BusW     = r_busw;
   assign PendMask = w_pend;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: a directed vector table, hand sequences
// for ordering and reset, then random traffic against a timestamp-based model.
module tb_regfile_write_arbiter;

   localparam int unsigned DATA_W   = 64;
   localparam int unsigned ADDR_W   = 5;
   localparam int unsigned ZERO_REG = 31;

   logic              Clk = 1'b0;
   logic              Reset;
   logic              Req0Valid, Req1Valid;
   logic              Req0Ready, Req1Ready;
   logic [ADDR_W-1:0] Req0RW, Req1RW;
   logic [DATA_W-1:0] Req0Data, Req1Data;
   logic              RegWr;
   logic [ADDR_W-1:0] RW;
   logic [DATA_W-1:0] BusW;
   logic [31:0]       PendMask;

   int checks = 0;
   int errors = 0;

   regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) dut (
      .Clk(Clk), .Reset(Reset),
      .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0RW(Req0RW), .Req0Data(Req0Data),
      .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1RW(Req1RW), .Req1Data(Req1Data),
      .RegWr(RegWr), .RW(RW), .BusW(BusW), .PendMask(PendMask)
   );

   always #5 Clk = ~Clk;

   // Register file as seen by the consumer: written on the falling edge
   logic [DATA_W-1:0] tb_rf [32];
   always @(negedge Clk) if (RegWr) tb_rf[RW] <= BusW;

   // Reference model: buffers carry the cycle they were loaded in
   bit                m_v  [2];
   logic [ADDR_W-1:0] m_rw [2];
   logic [DATA_W-1:0] m_d  [2];
   int                m_t  [2];
   int                m_rr;
   bit                m_wr;
   logic [ADDR_W-1:0] m_rwo;
   logic [DATA_W-1:0] m_bus;
   int                cyc = 0;

   typedef struct {
      bit rst; bit v0; logic [4:0] rw0; logic [63:0] d0;
      bit v1; logic [4:0] rw1; logic [63:0] d1;
      bit r0; bit r1; bit wr; logic [4:0] rw; logic [63:0] bus; logic [31:0] pend;
   } vec_t;

   vec_t tv [17];

   function automatic vec_t mk(bit rst, bit v0, logic [4:0] rw0, logic [63:0] d0,
                               bit v1, logic [4:0] rw1, logic [63:0] d1,
                               bit r0, bit r1, bit wr, logic [4:0] rw,
                               logic [63:0] bus, logic [31:0] pend);
      vec_t v;
      v.rst = rst; v.v0 = v0; v.rw0 = rw0; v.d0 = d0; v.v1 = v1; v.rw1 = rw1; v.d1 = d1;
      v.r0 = r0; v.r1 = r1; v.wr = wr; v.rw = rw; v.bus = bus; v.pend = pend;
      return v;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   // Who the model would grant right now: -1 none, else port number
   function automatic int m_grant();
      if (m_v[0] && !m_v[1]) return 0;
      if (!m_v[0] && m_v[1]) return 1;
      if (!m_v[0] && !m_v[1]) return -1;
      if (m_rw[0] == m_rw[1] && m_rw[0] != ADDR_W'(ZERO_REG))
         return (m_t[0] <= m_t[1]) ? 0 : 1;
      return m_rr;
   endfunction

   task automatic m_reset();
      m_v[0] = 0; m_v[1] = 0; m_rr = 0; m_wr = 0; m_rwo = '0; m_bus = '0;
   endtask

   task automatic apply(bit rst, bit v0, logic [4:0] rw0, logic [63:0] d0,
                        bit v1, logic [4:0] rw1, logic [63:0] d1);
      Reset = rst; Req0Valid = v0; Req0RW = rw0; Req0Data = d0;
      Req1Valid = v1; Req1RW = rw1; Req1Data = d1;
      #2;
   endtask

   // Compare the DUT with the model, then advance both across one edge
   task automatic finish_cycle();
      int g;
      bit er0, er1;
      logic [31:0] ep;
      g   = m_grant();
      er0 = !Reset && (!m_v[0] || g == 0);
      er1 = !Reset && (!m_v[1] || g == 1);
      ep  = '0;
      if (!Reset) begin
         for (int i = 0; i < 2; i++) if (m_v[i]) ep[m_rw[i]] = 1'b1;
         if (m_wr) ep[m_rwo] = 1'b1;
         ep[ZERO_REG] = 1'b0;
      end
      chk("model_ready0", 64'(Req0Ready), 64'(er0));
      chk("model_ready1", 64'(Req1Ready), 64'(er1));
      chk("model_regwr",  64'(RegWr),     64'(m_wr));
      chk("model_rw",     64'(RW),        64'(m_rwo));
      chk("model_busw",   BusW,           m_bus);
      chk("model_pend",   64'(PendMask),  64'(ep));
      @(posedge Clk);
      if (Reset) begin
         m_reset();
      end else begin
         if (g >= 0) begin
            m_rwo = m_rw[g]; m_bus = m_d[g]; m_wr = (m_rw[g] != ADDR_W'(ZERO_REG));
            if (m_v[0] && m_v[1] && !(m_rw[0] == m_rw[1] && m_rw[0] != ADDR_W'(ZERO_REG)))
               m_rr = 1 - g;
         end else begin
            m_wr = 0;
         end
         if (Req0Valid && er0) begin
            m_v[0] = 1; m_rw[0] = Req0RW; m_d[0] = Req0Data; m_t[0] = cyc;
         end else if (g == 0) m_v[0] = 0;
         if (Req1Valid && er1) begin
            m_v[1] = 1; m_rw[1] = Req1RW; m_d[1] = Req1Data; m_t[1] = cyc;
         end else if (g == 1) m_v[1] = 0;
      end
      cyc++;
      #1;
   endtask

   function automatic logic [4:0] pick_rw();
      case ($urandom_range(0, 3))
         0: return 5'd5;
         1: return 5'd6;
         2: return 5'd31;
         default: return 5'($urandom_range(0, 31));
      endcase
   endfunction

   initial begin
      // rows: inputs, then expected ready0, ready1, RegWr, RW, BusW, PendMask
      tv[0]  = mk(1, 0, 0, 0,       0, 0, 0,     0, 0, 0, 0,  0,       0);
      tv[1]  = mk(0, 1, 3, 'hA5,    0, 0, 0,     1, 1, 0, 0,  0,       0);
      tv[2]  = mk(0, 0, 0, 0,       0, 0, 0,     1, 1, 0, 0,  0,       'h8);
      tv[3]  = mk(0, 0, 0, 0,       0, 0, 0,     1, 1, 1, 3,  'hA5,    'h8);
      tv[4]  = mk(0, 0, 0, 0,       0, 0, 0,     1, 1, 0, 3,  'hA5,    0);
      tv[5]  = mk(0, 1, 31, 'hFFFF, 0, 0, 0,     1, 1, 0, 3,  'hA5,    0);
      tv[6]  = mk(0, 0, 0, 0,       0, 0, 0,     1, 1, 0, 3,  'hA5,    0);
      tv[7]  = mk(0, 0, 0, 0,       0, 0, 0,     1, 1, 0, 31, 'hFFFF,  0);
      tv[8]  = mk(1, 1, 4, 'h40,    1, 9, 'h90,  0, 0, 0, 31, 'hFFFF,  0);
      tv[9]  = mk(0, 1, 4, 'h40,    1, 9, 'h90,  1, 1, 0, 0,  0,       0);
      tv[10] = mk(0, 1, 4, 'h40,    1, 9, 'h90,  1, 0, 0, 0,  0,       'h210);
      tv[11] = mk(0, 1, 4, 'h40,    1, 9, 'h90,  0, 1, 1, 4,  'h40,    'h210);
      tv[12] = mk(0, 1, 4, 'h40,    1, 9, 'h90,  1, 0, 1, 9,  'h90,    'h210);
      tv[13] = mk(0, 0, 0, 0,       0, 0, 0,     0, 1, 1, 4,  'h40,    'h210);
      tv[14] = mk(0, 0, 0, 0,       0, 0, 0,     1, 1, 1, 9,  'h90,    'h210);
      tv[15] = mk(0, 0, 0, 0,       0, 0, 0,     1, 1, 1, 4,  'h40,    'h10);
      tv[16] = mk(0, 0, 0, 0,       0, 0, 0,     1, 1, 0, 4,  'h40,    0);

      // Initial reset brings DUT and model to a known state
      Reset = 1; Req0Valid = 0; Req1Valid = 0;
      Req0RW = '0; Req1RW = '0; Req0Data = '0; Req1Data = '0;
      m_reset();
      repeat (2) @(posedge Clk);
      #1;

      // Directed vector table
      for (int i = 0; i < 17; i++) begin
         apply(tv[i].rst, tv[i].v0, tv[i].rw0, tv[i].d0, tv[i].v1, tv[i].rw1, tv[i].d1);
         chk($sformatf("vec%0d_ready0", i), 64'(Req0Ready), 64'(tv[i].r0));
         chk($sformatf("vec%0d_ready1", i), 64'(Req1Ready), 64'(tv[i].r1));
         chk($sformatf("vec%0d_regwr", i),  64'(RegWr),     64'(tv[i].wr));
         chk($sformatf("vec%0d_rw", i),     64'(RW),        64'(tv[i].rw));
         chk($sformatf("vec%0d_busw", i),   BusW,           tv[i].bus);
         chk($sformatf("vec%0d_pend", i),   64'(PendMask),  64'(tv[i].pend));
         finish_cycle();
      end

      // Same-register ordering: port 1 data=1 first, then port 0 data=2
      apply(0, 0, 0, 0, 1, 7, 1);
      finish_cycle();
      apply(0, 1, 7, 2, 0, 0, 0);
      finish_cycle();
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("waw_first_wr",   64'(RegWr), 64'd1);
      chk("waw_first_data", BusW,       64'd1);
      finish_cycle();
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("waw_second_data", BusW, 64'd2);
      finish_cycle();
      apply(0, 0, 0, 0, 0, 0, 0);
      chk("waw_rf_final", tb_rf[7], 64'd2);
      finish_cycle();

      // Reset with both buffers full discards them
      apply(0, 1, 10, 'hAA, 1, 11, 'hBB);
      finish_cycle();
      apply(1, 0, 0, 0, 0, 0, 0);
      chk("rst_ready0_low", 64'(Req0Ready), 64'd0);
      chk("rst_pend_low",   64'(PendMask),  64'd0);
      finish_cycle();
      for (int k = 0; k < 3; k++) begin
         apply(0, 0, 0, 0, 0, 0, 0);
         chk($sformatf("rst_after%0d_regwr", k), 64'(RegWr),     64'd0);
         chk($sformatf("rst_after%0d_pend", k),  64'(PendMask),  64'd0);
         chk($sformatf("rst_after%0d_ready0", k), 64'(Req0Ready), 64'd1);
         chk($sformatf("rst_after%0d_ready1", k), 64'(Req1Ready), 64'd1);
         finish_cycle();
      end

      // Random traffic against the model
      for (int n = 0; n < 600; n++) begin
         apply(($urandom_range(0, 49) == 0),
               ($urandom_range(0, 2) != 0), pick_rw(), {$urandom, $urandom},
               ($urandom_range(0, 2) != 0), pick_rw(), {$urandom, $urandom});
         finish_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (RegWr/RW/BusW) between two writeback requesters: port 0 (ALU result) and port 1 (memory load data).
- Buffers one write per requester and arbitrates with age-then-round-robin priority, issuing at most one commit per cycle.
- Commit outputs are registered on posedge Clk, so they are stable when the register file samples on negedge Clk.
- Exports a pending-write mask for hazard detection.

Parameters:
- DATA_W, 64, width of write data
- ADDR_W, 5, register index width
- ZERO_REG, 31, index of the hardwired-zero register; writes to it are accepted and discarded

Ports:
- Clk  input  1  clock; all state updates on posedge
- Reset  input  1  synchronous, active-high reset
- Req0Valid  input  1  port 0 write request valid
- Req0Ready  output  1  port 0 can accept this cycle
- Req0RW  input  ADDR_W  port 0 destination register
- Req0Data  input  DATA_W  port 0 write data
- Req1Valid  input  1  port 1 write request valid
- Req1Ready  output  1  port 1 can accept this cycle
- Req1RW  input  ADDR_W  port 1 destination register
- Req1Data  input  DATA_W  port 1 write data
- RegWr  output  1  register-file write enable (registered)
- RW  output  ADDR_W  register-file write index (registered)
- BusW  output  DATA_W  register-file write data (registered)
- PendMask  output  32  bit r = 1 while a write to r is buffered or is on the commit outputs

Behaviour:
- Reset
  - While Reset=1 at posedge: both buffers invalid, RegWr=0, RW=0, BusW=0, age flag cleared, round-robin pointer=0 (port 0 preferred).
  - Req0Ready=Req1Ready=0 while Reset is high.
  - Reset mid-operation discards buffered writes; nothing is committed after Reset is asserted.
- Buffers
  - One entry per port: valid, rw, data.
  - Accept on port i when ReqiValid & ReqiReady at posedge; the entry loads on that edge.
  - ReqiReady = !Reset & (!buf_i.valid | grant_i), with grant_i combinational from buffer state. A single port can therefore stream one write per cycle.
- Age tracking
  - Flag `older` records which buffer was loaded first while both are valid.
  - If both buffers load on the same edge, port 0 is treated as older.
- Grant (combinational, applied at posedge)
  - Only one buffer valid: grant it.
  - Both valid and same rw (≠ ZERO_REG): grant the older one, preserving WAW order.
  - Both valid, different rw: grant per round-robin pointer. The pointer then points at the other port; it updates only on contended grants.
- Commit
  - On a grant edge: RW <= buf.rw, BusW <= buf.data, and the buffer is freed or reloaded.
  - RegWr <= 1 if buf.rw ≠ ZERO_REG, else RegWr <= 0 (dropped write).
  - On edges with no grant: RegWr <= 0. RW and BusW hold their previous values.
- Latency
  - Accept at posedge N → outputs valid from posedge N+1 → register file writes at the negedge in cycle N+1.
  - Uncontended latency is 1 cycle; a contended loser waits 1 additional cycle per lost grant.
  - Worst case is 2 cycles, since round-robin and age rules prevent starvation.
- PendMask
  - Combinational OR of: one-hot(buf0.rw) if buf0 valid; one-hot(buf1.rw) if buf1 valid; one-hot(RW) if RegWr.
  - Bit ZERO_REG is always 0. PendMask is 0 during and immediately after reset.
- Throughput: at most one commit per cycle total. Both ports continuously valid → alternating commits, each port sustaining 1 write per 2 cycles.

Test Plan:
- Reset, then Req0 only, RW=3, Data=64'hA5: accepted at edge 1 → RegWr=1, RW=3, BusW=A5 after edge 2. PendMask[3]=1 from edge 1 until RegWr drops at edge 3.
- Both ports valid same cycle, RW 4 and 9, held valid for 4 cycles: commits alternate 4, 9, 4, 9 with RegWr continuously 1. Ports first see ready at reset exit, with port 0 granted first.
- Port 1 buffered with RW=7 data=1; next cycle port 0 loads RW=7 data=2: commits are data=1 then data=2, giving a register-file final value of 2.
- Req0 RW=31 Data=FFFF: Req0Ready=1 and the write is accepted, but RegWr stays 0 and PendMask stays 0.
- Fill both buffers, then assert Reset for one cycle: RegWr=0 and PendMask=0 after the edge, no later commit of the discarded data, and ready returns to 1 the cycle Reset deasserts.
